// File: rtl/clk_div_multi_if.sv
// Config port of clk_div_multi: one timing update per valid&ready edge; ready is combinational on cfg_ch.
// The requester holds cfg_valid and payload stable until it sees cfg_ready high at a clock edge.
interface clk_div_multi_if #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 11
);
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [CNT_W-1:0] cfg_period;
  logic [CNT_W-1:0] cfg_high;

  modport master (
    output cfg_valid, cfg_ch, cfg_period, cfg_high,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_period, cfg_high,
    output cfg_ready
  );
endinterface

// File: rtl/clk_div_multi.sv
// N-channel programmable divider: registered clk_out/tick, first high cycle one clock after en is sampled.
// Config backpressure per channel: cfg_ready drops while that channel holds a pending shadow config.
module clk_div_multi #(
  parameter int N_CH       = 4,
  parameter int CNT_W      = 11,
  parameter int DEF_PERIOD = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_CH-1:0]   en,
  clk_div_multi_if.slave    cfg,
  output logic [N_CH-1:0]   clk_out,
  output logic [N_CH-1:0]   tick,
  output logic [N_CH-1:0]   busy
);
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef struct packed {
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high;
  } timing_t;

  localparam timing_t DEF_TIMING = '{
    period: CNT_W'(DEF_PERIOD),
    high:   CNT_W'(DEF_PERIOD >> 1)
  };

  logic [N_CH-1:0] busy_v;
  logic            ch_ok;
  logic            cfg_rdy;
  logic            accept;
  timing_t         cfg_in;

  assign ch_ok  = (int'(cfg.cfg_ch) < N_CH);
  assign cfg_in = '{period: cfg.cfg_period, high: cfg.cfg_high};

  // Out-of-range channels are always ready so the request is consumed and dropped.
  always_comb begin
    cfg_rdy = 1'b1;
    if (ch_ok) begin
      cfg_rdy = ~busy_v[cfg.cfg_ch];
    end
  end

  assign cfg.cfg_ready = cfg_rdy;
  assign accept        = cfg.cfg_valid & cfg_rdy;
  assign busy          = busy_v;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    timing_t          act_q, act_d;
    timing_t          shd_q, shd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] per_e, high_e;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             busy_q, busy_d;
    logic             hit, wrap, apply;

    assign per_e  = (act_q.period < CNT_W'(2)) ? CNT_W'(2) : act_q.period;
    assign high_e = (act_q.high < per_e) ? act_q.high : (per_e - CNT_W'(1));

    assign hit   = accept & ch_ok & (cfg.cfg_ch == CH_W'(g));
    assign wrap  = en[g] & (cnt_q == (per_e - CNT_W'(1)));
    // Pending values land only at a period boundary or when the channel stops.
    assign apply = busy_q & (wrap | ~en[g]);

    // Outputs reflect the phase held in cnt_q at the edge, so the period in
    // flight always finishes with the timing it started with.
    always_comb begin
      cnt_d  = '0;
      clk_d  = 1'b0;
      tick_d = 1'b0;
      act_d  = act_q;
      shd_d  = shd_q;
      busy_d = busy_q;
      if (en[g]) begin
        cnt_d  = wrap ? '0 : (cnt_q + CNT_W'(1));
        clk_d  = (cnt_q < high_e);
        tick_d = wrap;
      end
      if (apply) begin
        act_d  = shd_q;
        busy_d = 1'b0;
      end
      if (hit) begin
        shd_d = cfg_in;
        if (en[g]) begin
          busy_d = 1'b1;
        end else begin
          act_d = cfg_in;
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        act_q  <= DEF_TIMING;
        shd_q  <= DEF_TIMING;
        cnt_q  <= '0;
        clk_q  <= 1'b0;
        tick_q <= 1'b0;
        busy_q <= 1'b0;
      end else begin
        act_q  <= act_d;
        shd_q  <= shd_d;
        cnt_q  <= cnt_d;
        clk_q  <= clk_d;
        tick_q <= tick_d;
        busy_q <= busy_d;
      end
    end

    assign clk_out[g] = clk_q;
    assign tick[g]    = tick_q;
    assign busy_v[g]  = busy_q;
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi: one task per scenario, each with hand-computed expected waveforms.
module tb_clk_div_multi;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] en;
  wire  [3:0] clk_out;
  wire  [3:0] tick;
  wire  [3:0] busy;
  int         total = 0;
  int         bad   = 0;

  clk_div_multi_if #(.N_CH(4), .CNT_W(11)) cfg_if ();

  clk_div_multi #(.N_CH(4), .CNT_W(11), .DEF_PERIOD(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .cfg     (cfg_if),
    .clk_out (clk_out),
    .tick    (tick),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input logic v, input logic [1:0] ch, input int per, input int hi);
    cfg_if.cfg_valid  = v;
    cfg_if.cfg_ch     = ch;
    cfg_if.cfg_period = 11'(per);
    cfg_if.cfg_high   = 11'(hi);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en    = 4'b0000;
    set_cfg(1'b0, 2'd0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en    = 4'b1111;
    set_cfg(1'b0, 2'd0, 0, 0);
    #1;
    total++; if (clk_out !== 4'b0000) begin bad++; $display("FAIL rst_clk: got=%b exp=0000", clk_out); end
    repeat (2) @(posedge clk);
    #1;
    total++; if (tick !== 4'b0000) begin bad++; $display("FAIL rst_tick: got=%b exp=0000", tick); end
    total++; if (busy !== 4'b0000) begin bad++; $display("FAIL rst_busy: got=%b exp=0000", busy); end
    total++; if (cfg_if.cfg_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got=%b exp=1", cfg_if.cfg_ready); end
    total++; if (clk_out !== 4'b0000) begin bad++; $display("FAIL rst_clk_held: got=%b exp=0000", clk_out); end
  endtask

  task automatic test_default();
    logic [7:0] exp_c;
    logic [7:0] exp_t;
    exp_c = 8'b0011_0011;
    exp_t = 8'b1000_1000;
    do_reset();
    en = 4'b0001;
    for (int c = 0; c < 8; c++) begin
      step();
      total++; if (clk_out !== {3'b000, exp_c[c]}) begin bad++; $display("FAIL def_clk c=%0d: got=%b exp=%b", c, clk_out, {3'b000, exp_c[c]}); end
      total++; if (tick !== {3'b000, exp_t[c]}) begin bad++; $display("FAIL def_tick c=%0d: got=%b exp=%b", c, tick, {3'b000, exp_t[c]}); end
    end
  endtask

  task automatic test_reprogram();
    logic [10:0] exp_c;
    logic [10:0] exp_t;
    logic [10:0] exp_b;
    exp_c = 11'b100_0110_0110;
    exp_t = 11'b010_0001_0000;
    exp_b = 11'b000_0000_1000;
    do_reset();
    en = 4'b0010;
    for (int c = 1; c <= 10; c++) begin
      step();
      total++; if (clk_out[1] !== exp_c[c]) begin bad++; $display("FAIL reprog_clk c=%0d: got=%b exp=%b", c, clk_out[1], exp_c[c]); end
      total++; if (tick[1] !== exp_t[c]) begin bad++; $display("FAIL reprog_tick c=%0d: got=%b exp=%b", c, tick[1], exp_t[c]); end
      total++; if (busy[1] !== exp_b[c]) begin bad++; $display("FAIL reprog_busy c=%0d: got=%b exp=%b", c, busy[1], exp_b[c]); end
      if (c == 2) begin
        set_cfg(1'b1, 2'd1, 5, 2);
        #1;
        total++; if (cfg_if.cfg_ready !== 1'b1) begin bad++; $display("FAIL reprog_ready: got=%b exp=1", cfg_if.cfg_ready); end
      end
      if (c == 3) set_cfg(1'b0, 2'd0, 0, 0);
    end
  endtask

  task automatic test_min_period();
    do_reset();
    set_cfg(1'b1, 2'd2, 0, 7);
    step();
    total++; if (busy !== 4'b0000) begin bad++; $display("FAIL minper_busy2: got=%b exp=0000", busy); end
    set_cfg(1'b1, 2'd3, 1, 1);
    step();
    total++; if (busy !== 4'b0000) begin bad++; $display("FAIL minper_busy3: got=%b exp=0000", busy); end
    set_cfg(1'b0, 2'd0, 0, 0);
    en = 4'b1100;
    for (int c = 1; c <= 6; c++) begin
      step();
      total++; if (clk_out !== ((c % 2 == 1) ? 4'b1100 : 4'b0000)) begin bad++; $display("FAIL minper_clk c=%0d: got=%b exp=%b", c, clk_out, (c % 2 == 1) ? 4'b1100 : 4'b0000); end
      total++; if (tick !== ((c % 2 == 0) ? 4'b1100 : 4'b0000)) begin bad++; $display("FAIL minper_tick c=%0d: got=%b exp=%b", c, tick, (c % 2 == 0) ? 4'b1100 : 4'b0000); end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_b;
    do_reset();
    en = 4'b0011;
    for (int c = 1; c <= 15; c++) begin
      step();
      if (c >= 3 && c <= 9) begin
        case (c)
          3, 5, 8: exp_b = 2'b10;
          6, 7:    exp_b = 2'b11;
          default: exp_b = 2'b00;
        endcase
        total++; if (busy[1:0] !== exp_b) begin bad++; $display("FAIL b2b_busy c=%0d: got=%b exp=%b", c, busy[1:0], exp_b); end
      end
      if (c >= 10) begin
        total++; if (clk_out[1:0] !== ((c <= 12) ? 2'b11 : 2'b00)) begin bad++; $display("FAIL b2b_clk c=%0d: got=%b exp=%b", c, clk_out[1:0], (c <= 12) ? 2'b11 : 2'b00); end
      end
      case (c)
        2: set_cfg(1'b1, 2'd1, 5, 2);
        3: begin
          set_cfg(1'b1, 2'd1, 6, 3);
          #1;
          total++; if (cfg_if.cfg_ready !== 1'b0) begin bad++; $display("FAIL b2b_blocked: got=%b exp=0", cfg_if.cfg_ready); end
        end
        4: begin
          total++; if (cfg_if.cfg_ready !== 1'b1) begin bad++; $display("FAIL b2b_released: got=%b exp=1", cfg_if.cfg_ready); end
        end
        5: begin
          set_cfg(1'b1, 2'd0, 8, 4);
          #1;
          total++; if (cfg_if.cfg_ready !== 1'b1) begin bad++; $display("FAIL b2b_ch0_ready: got=%b exp=1", cfg_if.cfg_ready); end
        end
        6: set_cfg(1'b0, 2'd0, 0, 0);
        default: ;
      endcase
    end
  endtask

  task automatic test_disable_pending();
    do_reset();
    en = 4'b0100;
    for (int c = 1; c <= 11; c++) begin
      step();
      if (c == 2) begin
        total++; if (busy[2] !== 1'b1) begin bad++; $display("FAIL dis_busy_set: got=%b exp=1", busy[2]); end
        total++; if (clk_out[2] !== 1'b1) begin bad++; $display("FAIL dis_mid_high: got=%b exp=1", clk_out[2]); end
      end
      if (c == 3) begin
        total++; if (clk_out[2] !== 1'b0) begin bad++; $display("FAIL dis_clk_low: got=%b exp=0", clk_out[2]); end
        total++; if (busy[2] !== 1'b0) begin bad++; $display("FAIL dis_busy_clr: got=%b exp=0", busy[2]); end
        total++; if (tick[2] !== 1'b0) begin bad++; $display("FAIL dis_tick: got=%b exp=0", tick[2]); end
      end
      if (c >= 5) begin
        total++; if (clk_out[2] !== (c <= 7 || c == 11)) begin bad++; $display("FAIL dis_reen_clk c=%0d: got=%b exp=%b", c, clk_out[2], (c <= 7 || c == 11)); end
        total++; if (tick[2] !== (c == 10)) begin bad++; $display("FAIL dis_reen_tick c=%0d: got=%b exp=%b", c, tick[2], (c == 10)); end
      end
      case (c)
        1: set_cfg(1'b1, 2'd2, 6, 3);
        2: begin set_cfg(1'b0, 2'd0, 0, 0); en = 4'b0000; end
        4: en = 4'b0100;
        default: ;
      endcase
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    en = 4'b1111;
    step();
    set_cfg(1'b1, 2'd0, 8, 4);
    step();
    set_cfg(1'b0, 2'd0, 0, 0);
    total++; if (busy !== 4'b0001) begin bad++; $display("FAIL arst_busy_pre: got=%b exp=0001", busy); end
    total++; if (clk_out !== 4'b1111) begin bad++; $display("FAIL arst_clk_pre: got=%b exp=1111", clk_out); end
    #3;
    rst_n = 1'b0;
    #1;
    total++; if (clk_out !== 4'b0000) begin bad++; $display("FAIL arst_clk: got=%b exp=0000", clk_out); end
    total++; if (busy !== 4'b0000) begin bad++; $display("FAIL arst_busy: got=%b exp=0000", busy); end
    #2;
    rst_n = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      step();
      total++; if (clk_out !== ((c % 4 == 1 || c % 4 == 2) ? 4'b1111 : 4'b0000)) begin bad++; $display("FAIL arst_after_clk c=%0d: got=%b", c, clk_out); end
      total++; if (tick !== ((c % 4 == 0) ? 4'b1111 : 4'b0000)) begin bad++; $display("FAIL arst_after_tick c=%0d: got=%b", c, tick); end
    end
  endtask

  initial begin
    test_reset();
    test_default();
    test_reprogram();
    test_min_period();
    test_back_to_back();
    test_disable_pending();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
